// File: rtl/dropbox_pkg.sv
// Shared types and constants for the dropbox master slice.
package dropbox_pkg;

    localparam int DROPBOX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_CAP
    } state_t;

endpackage

// File: rtl/dropbox_master_if.sv
// Dropbox register bus: one write port and one read port, both single-cycle strobed.
interface dropbox_master_if;
    import dropbox_pkg::*;

    logic [DROPBOX_W-1:0] OUTBUS_ADDR;
    logic [DROPBOX_W-1:0] OUTBUS_DATA;
    logic                 OUTBUS_WE;
    logic [DROPBOX_W-1:0] INBUS_ADDR;
    logic                 INBUS_RE;
    logic [DROPBOX_W-1:0] INBUS_DATA;

    modport master (
        output OUTBUS_ADDR,
        output OUTBUS_DATA,
        output OUTBUS_WE,
        output INBUS_ADDR,
        output INBUS_RE,
        input  INBUS_DATA
    );

    modport slave (
        input  OUTBUS_ADDR,
        input  OUTBUS_DATA,
        input  OUTBUS_WE,
        input  INBUS_ADDR,
        input  INBUS_RE,
        output INBUS_DATA
    );

endinterface

// File: rtl/dropbox_poll_timer.sv
// Poll interval counter: reloads to POLL_DIV-1, counts down while enabled, saturates at zero.
module dropbox_poll_timer #(
    parameter logic [15:0] POLL_DIV = 16'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [15:0] count;

    // Reload on reset or after a completed poll, otherwise count down to zero and stick there.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= POLL_DIV - 16'd1;
        end else if (dec && (count != '0)) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dropbox_master.sv
// Dropbox master: pushes tx bytes to a dropbox register and polls it for changed bytes.
// Optional macro DROPBOX_MASTER_RXCNT_EN adds an 8-bit rx_count output counting rx_valid pulses.
module dropbox_master
    import dropbox_pkg::*;
#(
    parameter logic [7:0]  DEVADDR  = 8'h00,
    parameter logic [15:0] POLL_DIV = 16'd4
) (
    input  logic                  clk,
    input  logic                  reset,
    dropbox_master_if.master      bus,
    input  logic [DROPBOX_W-1:0]  tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DROPBOX_W-1:0]  rx_data,
    output logic                  rx_valid
`ifdef DROPBOX_MASTER_RXCNT_EN
    ,
    output logic [7:0]            rx_count
`endif
);

    state_t               state;
    logic [DROPBOX_W-1:0] last_rx;
    logic                 poll_zero;

    dropbox_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state == RD_CAP),
        .dec   (state == IDLE),
        .zero  (poll_zero)
    );

    // Main FSM; every output is registered and defaults to 0 outside its strobe cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            tx_ready        <= 1'b1;
            rx_valid        <= 1'b0;
            rx_data         <= '0;
            last_rx         <= '0;
            bus.OUTBUS_WE   <= 1'b0;
            bus.OUTBUS_ADDR <= '0;
            bus.OUTBUS_DATA <= '0;
            bus.INBUS_RE    <= 1'b0;
            bus.INBUS_ADDR  <= '0;
        end else begin
            tx_ready        <= 1'b0;
            rx_valid        <= 1'b0;
            bus.OUTBUS_WE   <= 1'b0;
            bus.OUTBUS_ADDR <= '0;
            bus.OUTBUS_DATA <= '0;
            bus.INBUS_RE    <= 1'b0;
            bus.INBUS_ADDR  <= '0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        // A pending write always beats an expired poll.
                        state           <= WR;
                        bus.OUTBUS_WE   <= 1'b1;
                        bus.OUTBUS_ADDR <= DEVADDR;
                        bus.OUTBUS_DATA <= tx_data;
                    end else if (poll_zero) begin
                        state          <= RD_REQ;
                        bus.INBUS_RE   <= 1'b1;
                        bus.INBUS_ADDR <= DEVADDR;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                WR: begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                end
                RD_REQ: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    // Only a changed byte counts as a new message.
                    if (bus.INBUS_DATA != last_rx) begin
                        last_rx  <= bus.INBUS_DATA;
                        rx_data  <= bus.INBUS_DATA;
                        rx_valid <= 1'b1;
                    end
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DROPBOX_MASTER_RXCNT_EN
    // Free-running count of received bytes, wrapping at 256.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count <= '0;
        end else if (rx_valid) begin
            rx_count <= rx_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dropbox_master.sv
// Self-checking bench for dropbox_master with a transaction-level reference model.
module tb_dropbox_master;
    import dropbox_pkg::*;

    localparam logic [7:0] DEV  = 8'h5A;
    localparam int         POLL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef DROPBOX_MASTER_RXCNT_EN
    logic [7:0] rx_count;
`endif

    int tests = 0;
    int fails = 0;

    dropbox_master_if bus();

    dropbox_master #(
        .DEVADDR  (DEV),
        .POLL_DIV (16'(POLL))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef DROPBOX_MASTER_RXCNT_EN
        ,
        .rx_count (rx_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the master is either free, or busy for a known number of
    // cycles; a poll fires once POLL-1 free cycles have elapsed since the last one.
    bit         m_on = 1'b0;
    int         busy = 0;
    int         idle_seen = 0;
    bit         reading = 1'b0;
    bit         m_we = 1'b0, m_re = 1'b0, m_rxv = 1'b0, m_ready = 1'b1, prev_rxv = 1'b0;
    logic [7:0] m_wdata = 8'h00, m_last = 8'h00, m_rxd = 8'h00;
    int         m_cnt = 0;

    always @(posedge clk) begin
        prev_rxv = m_rxv;
        m_we  = 1'b0;
        m_re  = 1'b0;
        m_rxv = 1'b0;
        if (reset) begin
            busy      = 0;
            reading   = 1'b0;
            idle_seen = 0;
            m_last    = 8'h00;
            m_rxd     = 8'h00;
            m_cnt     = 0;
        end else begin
            if (prev_rxv) m_cnt = (m_cnt + 1) % 256;
            if (busy == 0) begin
                if (tx_valid) begin
                    m_we    = 1'b1;
                    m_wdata = tx_data;
                    busy    = 1;
                end else if (idle_seen >= POLL - 1) begin
                    m_re    = 1'b1;
                    busy    = 2;
                    reading = 1'b1;
                end
                idle_seen++;
            end else begin
                if (busy == 1 && reading) begin
                    reading   = 1'b0;
                    idle_seen = 0;
                    if (bus.INBUS_DATA != m_last) begin
                        m_last = bus.INBUS_DATA;
                        m_rxd  = bus.INBUS_DATA;
                        m_rxv  = 1'b1;
                    end
                end
                busy--;
            end
        end
        m_ready = (busy == 0);
        m_on    = 1'b1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_on) begin
            check("cmp_we",    int'(bus.OUTBUS_WE),   int'(m_we));
            check("cmp_waddr", int'(bus.OUTBUS_ADDR), m_we ? int'(DEV) : 0);
            check("cmp_wdata", int'(bus.OUTBUS_DATA), m_we ? int'(m_wdata) : 0);
            check("cmp_re",    int'(bus.INBUS_RE),    int'(m_re));
            check("cmp_raddr", int'(bus.INBUS_ADDR),  m_re ? int'(DEV) : 0);
            check("cmp_ready", int'(tx_ready),        int'(m_ready));
            check("cmp_rxv",   int'(rx_valid),        int'(m_rxv));
            check("cmp_rxd",   int'(rx_data),         int'(m_rxd));
`ifdef DROPBOX_MASTER_RXCNT_EN
            check("cmp_rxcnt", int'(rx_count),        m_cnt);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_re(input string name);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.INBUS_RE) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_ready(input string name);
        for (int n = 0; n < 20; n++) begin
            if (tx_ready) return;
            tick();
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int re_at[$];
        int rxv_n;
        bus.INBUS_DATA = 8'h00;

        // Reset state.
        reset = 1'b1;
        repeat (2) tick();
        check("rst_ready", int'(tx_ready),      1);
        check("rst_we",    int'(bus.OUTBUS_WE), 0);
        check("rst_re",    int'(bus.INBUS_RE),  0);
        check("rst_rxv",   int'(rx_valid),      0);
        check("rst_rxd",   int'(rx_data),       0);
        reset = 1'b0;

        // Idle polling with zero data: RE every 6 cycles, never rx_valid.
        rxv_n = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.INBUS_RE) re_at.push_back(i);
            if (rx_valid) rxv_n++;
        end
        check("poll_count", re_at.size(), 3);
        if (re_at.size() == 3) begin
            check("poll_first", re_at[0], 4);
            check("poll_gap1",  re_at[1] - re_at[0], 6);
            check("poll_gap2",  re_at[2] - re_at[1], 6);
        end
        check("poll_norx", rxv_n, 0);

        // Single write.
        wait_ready("wr_ready");
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        check("wr_we",    int'(bus.OUTBUS_WE),   1);
        check("wr_addr",  int'(bus.OUTBUS_ADDR), int'(DEV));
        check("wr_data",  int'(bus.OUTBUS_DATA), 8'hA5);
        check("wr_ready", int'(tx_ready),        0);
        tick();
        check("wr_after_we",   int'(bus.OUTBUS_WE),   0);
        check("wr_after_data", int'(bus.OUTBUS_DATA), 0);
        check("wr_after_rdy",  int'(tx_ready),        1);

        // New byte is reported 2 cycles after RE; a repeat is not.
        bus.INBUS_DATA = 8'h3C;
        wait_re("rx1_re");
        check("rx1_raddr", int'(bus.INBUS_ADDR), int'(DEV));
        tick();
        check("rx1_cap_rxv", int'(rx_valid), 0);
        tick();
        check("rx1_rxv", int'(rx_valid), 1);
        check("rx1_rxd", int'(rx_data),  8'h3C);
        wait_re("rx2_re");
        repeat (2) tick();
        check("rx2_rxv", int'(rx_valid), 0);
        check("rx2_rxd", int'(rx_data),  8'h3C);

        // Reset during RD_REQ aborts the read.
        bus.INBUS_DATA = 8'h77;
        wait_re("ab_re");
        reset = 1'b1;
        tick();
        check("ab_re_low", int'(bus.INBUS_RE), 0);
        check("ab_rxv",    int'(rx_valid),     0);
        check("ab_ready",  int'(tx_ready),     1);
        reset = 1'b0;
        tick();
        check("ab_rxv2", int'(rx_valid), 0);
        wait_re("ab_next_re");
        repeat (2) tick();
        check("ab_next_rxv", int'(rx_valid), 1);
        check("ab_next_rxd", int'(rx_data),  8'h77);

        // After reset, a zero byte matches the cleared history and is silent.
        reset = 1'b1;
        tick();
        check("clr_rxd", int'(rx_data), 0);
        reset = 1'b0;
        bus.INBUS_DATA = 8'h00;
        wait_re("clr_re");
        repeat (2) tick();
        check("clr_rxv", int'(rx_valid), 0);

        // Write collides with poll expiry: write first, poll next free cycle.
        wait_re("col_re");
        repeat (5) tick();
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        check("col_we",   int'(bus.OUTBUS_WE),   1);
        check("col_data", int'(bus.OUTBUS_DATA), 8'hC3);
        check("col_re0",  int'(bus.INBUS_RE),    0);
        tx_valid = 1'b0;
        tick();
        check("col_idle_we", int'(bus.OUTBUS_WE), 0);
        check("col_idle_re", int'(bus.INBUS_RE),  0);
        tick();
        check("col_re1", int'(bus.INBUS_RE), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            tick();
            reset    = ($urandom_range(0, 199) == 0);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.INBUS_DATA = 8'h00;
                    1: bus.INBUS_DATA = 8'h3C;
                    2: bus.INBUS_DATA = 8'h77;
                    default: bus.INBUS_DATA = 8'($urandom);
                endcase
            end
        end
        tick();
        reset    = 1'b0;
        tx_valid = 1'b0;

`ifdef DROPBOX_MASTER_RXCNT_EN
        // 256 alternating bytes wrap the receive counter back to zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        begin
            int pulses;
            int cycles;
            pulses = 0;
            cycles = 0;
            bus.INBUS_DATA = 8'h55;
            while (pulses < 256 && cycles < 3000) begin
                tick();
                cycles++;
                if (bus.INBUS_RE) bus.INBUS_DATA = (bus.INBUS_DATA == 8'h55) ? 8'hAA : 8'h55;
                if (rx_valid) pulses++;
            end
            check("cnt_pulses", pulses, 256);
            tick();
            check("cnt_wrap", int'(rx_count), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dropbox_master.md
DROPBOX_MASTER -- requirements
Module: dropbox_master

Interface
REQ-001 Parameter DEVADDR, 8'h00, bus address of the dropbox register this master talks to.
REQ-002 Parameter POLL_DIV, 16'd4, clocks between read polls (legal 1..65535).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 OUTBUS_ADDR  output  8  write address to dropbox.
REQ-006 OUTBUS_DATA  output  8  write data to dropbox.
REQ-007 OUTBUS_WE  output  1  write strobe, one-cycle pulse.
REQ-008 INBUS_ADDR  output  8  read address to dropbox.
REQ-009 INBUS_RE  output  1  read strobe, one-cycle pulse.
REQ-010 INBUS_DATA  input  8  read data, valid the cycle after INBUS_RE.
REQ-011 tx_data  input  8  byte to send.
REQ-012 tx_valid  input  1  tx_data offered.
REQ-013 tx_ready  output  1  master can accept a byte this cycle.
REQ-014 rx_data  output  8  newly received byte.
REQ-015 rx_valid  output  1  one-cycle pulse qualifying rx_data.

Function
REQ-016 FSM states SHALL be IDLE, WR, RD_REQ, RD_CAP; all bus outputs registered.
REQ-017 tx_ready SHALL be 1 only in IDLE; a byte is accepted when tx_valid && tx_ready.
REQ-018 On accept, next cycle (WR) SHALL drive OUTBUS_WE=1, OUTBUS_ADDR=DEVADDR, OUTBUS_DATA=accepted byte, then return to IDLE.
REQ-019 A 16-bit poll counter SHALL load POLL_DIV-1 on reset and after each RD_CAP, and decrement by 1 each IDLE cycle, saturating at 0.
REQ-020 In IDLE with counter 0 and no tx accept, FSM SHALL enter RD_REQ: INBUS_RE=1, INBUS_ADDR=DEVADDR for one cycle, then RD_CAP.
REQ-021 In RD_CAP, SHALL sample INBUS_DATA; if it differs from last_rx, load last_rx and rx_data with it and pulse rx_valid next cycle; else no pulse.
REQ-022 Simultaneous tx accept and poll expiry: tx SHALL win; counter holds 0 and poll runs on the next IDLE cycle without tx.
REQ-023 Outside strobe cycles OUTBUS_ADDR, OUTBUS_DATA, INBUS_ADDR SHALL be 0 and OUTBUS_WE, INBUS_RE 0.
REQ-024 Change detection is the link protocol: a repeated byte or byte 0x00 after reset SHALL NOT produce rx_valid.
REQ-025 Read-to-rx_valid latency SHALL be 2 cycles after INBUS_RE.
REQ-026 rx_data SHALL hold its value between pulses.

Reset
REQ-027 Reset SHALL force IDLE, all outputs 0 except tx_ready=1 the cycle after reset deasserts, last_rx=0, counter=POLL_DIV-1.
REQ-028 Reset mid-WR or mid-RD SHALL abort the transaction; no strobe, no rx_valid on the following cycle.

Configuration
REQ-029 Macro DROPBOX_MASTER_RXCNT_EN defined: extra output rx_count (8 bits, reset 0) SHALL increment on each rx_valid, wrapping 255->0.
REQ-030 Macro undefined: rx_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package dropbox_pkg SHALL hold the FSM state typedef and constant DROPBOX_W=8.
REQ-032 Sub-module dropbox_poll_timer SHALL implement the poll counter (load, decrement, zero flag).

Verification
REQ-033 Reset, POLL_DIV=4, INBUS_DATA=0 -> RE every 6 cycles, no rx_valid.
REQ-034 tx_data=8'hA5 with tx_valid in IDLE -> next cycle WE=1, ADDR=DEVADDR, DATA=8'hA5; tx_ready low that cycle.
REQ-035 INBUS_DATA=8'h3C on capture -> rx_valid pulse, rx_data=8'h3C 2 cycles after RE; same value next poll -> no pulse.
REQ-036 tx_valid held high when counter reaches 0 -> write first, RE on the following IDLE cycle.
REQ-037 Reset asserted during RD_REQ with INBUS_DATA=8'h77 -> no rx_valid, last_rx=0, next poll reports 8'h77.
REQ-038 With DROPBOX_MASTER_RXCNT_EN, 256 distinct alternating received bytes -> rx_count wraps to 0.
